// File: rtl/demod_pkg.sv
// Shared types for the demodulator sample FIFO: channel width, sequence width, stored sample layout.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package demod_pkg;

  localparam int DATA_W = 24;
  localparam int SEQ_W  = 32;

  // One coherent demodulator result as stored in the FIFO.
  typedef struct packed {
    logic [SEQ_W-1:0]         seq;
    logic signed [DATA_W-1:0] x1;
    logic signed [DATA_W-1:0] i1;
    logic signed [DATA_W-1:0] x2;
    logic signed [DATA_W-1:0] i2;
  } demod_sample_t;

endpackage

// File: rtl/demod_sample_fifo_if.sv
// Bus between the QPD demodulator / software readout and demod_sample_fifo (DEMOD_FIFO_DROP_COUNT_EN adds drop_cnt_o).
// Latency: pure wiring.
// Backpressure: none; the writer never stalls, and overflow is reported through ovf_o and the drop count.
interface demod_sample_fifo_if #(
  parameter int DATA_W = demod_pkg::DATA_W,
  parameter int DEPTH  = 16
) ();

  logic                      tick_i;
  logic signed [DATA_W-1:0]  x1_i, i1_i, x2_i, i2_i;
  logic                      rd_i;
  logic                      clr_ovf_i;
  logic signed [DATA_W-1:0]  x1_o, i1_o, x2_o, i2_o;
  logic [31:0]               seq_o;
  logic                      rd_valid_o;
  logic [$clog2(DEPTH):0]    level_o;
  logic                      empty_o;
  logic                      full_o;
  logic                      ovf_o;
`ifdef DEMOD_FIFO_DROP_COUNT_EN
  logic [31:0]               drop_cnt_o;
`endif

  // Demodulator and software side: drives samples, pops and clears.
  modport master (
`ifdef DEMOD_FIFO_DROP_COUNT_EN
    input  drop_cnt_o,
`endif
    output tick_i, x1_i, i1_i, x2_i, i2_i, rd_i, clr_ovf_i,
    input  x1_o, i1_o, x2_o, i2_o, seq_o, rd_valid_o, level_o, empty_o, full_o, ovf_o
  );

  // FIFO side.
  modport slave (
`ifdef DEMOD_FIFO_DROP_COUNT_EN
    output drop_cnt_o,
`endif
    input  tick_i, x1_i, i1_i, x2_i, i2_i, rd_i, clr_ovf_i,
    output x1_o, i1_o, x2_o, i2_o, seq_o, rd_valid_o, level_o, empty_o, full_o, ovf_o
  );

endinterface

// File: rtl/demod_sample_ram.sv
// Simple dual-port sample RAM: synchronous write, registered synchronous read.
// Latency: read data appears one cycle after rd_en and then holds until the next rd_en.
// Backpressure: none; the caller guarantees the addresses are valid.
module demod_sample_ram
  import demod_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  demod_sample_t wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output demod_sample_t rd_data
);

  demod_sample_t mem [DEPTH];

  // Storage write; contents are deliberately not reset so this maps onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read. Reading and writing one address in the same cycle returns the old entry.
  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/demod_sample_fifo.sv
// Demodulator sample FIFO: every pop returns one coherent {seq, x1, i1, x2, i2}; DEMOD_FIFO_DROP_COUNT_EN adds drop_cnt_o.
// Latency: a pop in cycle N shows data and rd_valid_o in N+1; a write in N is counted in level_o in N+1.
// Backpressure: none toward the writer; a tick into a full FIFO is dropped (unless a pop frees the slot) and sets ovf_o.
module demod_sample_fifo #(
  parameter int DEPTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  demod_sample_fifo_if.slave bus
);
  import demod_pkg::*;

  // Sample field widths follow demod_pkg::DATA_W; the bus must be built with the same width.
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level;
  logic [SEQ_W-1:0] seq_cnt;
  logic             ovf;
  logic             rd_valid;
  logic             empty, full;
  logic             push, pop, drop;
  demod_sample_t    wr_data, rd_data;

  // Status comes from the level register only, never directly from the inputs.
  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));

  // A pop into a full FIFO frees the slot that the simultaneous write then takes, so that case is not a drop.
  always_comb begin
    pop  = bus.rd_i & ~empty;
    push = bus.tick_i & (~full | bus.rd_i);
    drop = bus.tick_i & full & ~bus.rd_i;
  end

  assign wr_data = '{seq: seq_cnt, x1: bus.x1_i, i1: bus.i1_i, x2: bus.x2_i, i2: bus.i2_i};

  // Pointers, level and sequence counter; seq advances on every tick so gaps expose drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      seq_cnt  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (push)       wr_ptr  <= wr_ptr + AW'(1);
      if (pop)        rd_ptr  <= rd_ptr + AW'(1);
      if (bus.tick_i) seq_cnt <= seq_cnt + SEQ_W'(1);
      rd_valid <= pop;
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (reset)              ovf <= 1'b0;
    else if (drop)          ovf <= 1'b1;
    else if (bus.clr_ovf_i) ovf <= 1'b0;
  end

`ifdef DEMOD_FIFO_DROP_COUNT_EN
  logic [31:0] drop_cnt;

  // Saturating drop counter; a drop coinciding with a clear restarts the count at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop) begin
      if (bus.clr_ovf_i)       drop_cnt <= 32'd1;
      else if (drop_cnt != '1) drop_cnt <= drop_cnt + 32'd1;
    end else if (bus.clr_ovf_i) begin
      drop_cnt <= '0;
    end
  end

  assign bus.drop_cnt_o = drop_cnt;
`endif

  demod_sample_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // The RAM read register doubles as the output register, so outputs hold between pops.
  assign bus.x1_o       = rd_data.x1;
  assign bus.i1_o       = rd_data.i1;
  assign bus.x2_o       = rd_data.x2;
  assign bus.i2_o       = rd_data.i2;
  assign bus.seq_o      = rd_data.seq;
  assign bus.rd_valid_o = rd_valid;
  assign bus.level_o    = level;
  assign bus.empty_o    = empty;
  assign bus.full_o     = full;
  assign bus.ovf_o      = ovf;

endmodule

// File: tb/tb_demod_sample_fifo.sv
// Self-checking bench for demod_sample_fifo against a queue-based reference model (DEMOD_FIFO_DROP_COUNT_EN adds drop count checks).
// Latency: drives one cycle per step and checks every output one cycle later.
// Backpressure: not applicable.
module tb_demod_sample_fifo;

  localparam int DEPTH = 16;
  localparam int DW    = 24;

  typedef struct {
    int unsigned        seq;
    logic signed [DW-1:0] x1, i1, x2, i2;
  } smp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  demod_sample_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  demod_sample_fifo #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  smp_t        q[$];
  smp_t        m_out;
  int unsigned m_seq;
  bit          m_ovf;
  bit          m_valid;
  longint      m_drop;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("rd_valid", bus.rd_valid_o, m_valid);
    check("level", bus.level_o, q.size());
    check("empty", bus.empty_o, q.size() == 0);
    check("full", bus.full_o, q.size() == DEPTH);
    check("ovf", bus.ovf_o, m_ovf);
    check("seq_o", bus.seq_o, m_out.seq);
    check("x1_o", bus.x1_o, m_out.x1);
    check("i1_o", bus.i1_o, m_out.i1);
    check("x2_o", bus.x2_o, m_out.x2);
    check("i2_o", bus.i2_o, m_out.i2);
`ifdef DEMOD_FIFO_DROP_COUNT_EN
    check("drop_cnt", bus.drop_cnt_o, m_drop);
`endif
  endtask

  // One clock of stimulus: apply inputs, advance the model, then check after the edge.
  task automatic cycle(input bit tick, input bit rd, input bit clr, input bit rst, input int x1v);
    smp_t s;
    bit   dropped;
    dropped = 1'b0;
    s.seq = 0;
    s.x1  = x1v[DW-1:0];
    s.i1  = DW'($urandom);
    s.x2  = DW'($urandom);
    s.i2  = DW'($urandom);
    bus.tick_i    = tick;
    bus.x1_i      = s.x1;
    bus.i1_i      = s.i1;
    bus.x2_i      = s.x2;
    bus.i2_i      = s.i2;
    bus.rd_i      = rd;
    bus.clr_ovf_i = clr;
    reset         = rst;
    if (rst) begin
      q.delete();
      m_seq   = 0;
      m_ovf   = 1'b0;
      m_drop  = 0;
      m_valid = 1'b0;
      m_out   = '{default: 0};
    end else begin
      m_valid = 1'b0;
      if (rd && q.size() > 0) begin
        m_out   = q.pop_front();
        m_valid = 1'b1;
      end
      if (tick) begin
        s.seq = m_seq;
        m_seq++;
        if (q.size() < DEPTH) q.push_back(s);
        else dropped = 1'b1;
      end
      if (dropped) begin
        m_ovf  = 1'b1;
        m_drop = clr ? 1 : ((m_drop == 64'hFFFF_FFFF) ? m_drop : m_drop + 1);
      end else if (clr) begin
        m_ovf  = 1'b0;
        m_drop = 0;
      end
    end
    @(posedge clk);
    #1;
    bus.tick_i    = 1'b0;
    bus.rd_i      = 1'b0;
    bus.clr_ovf_i = 1'b0;
    reset         = 1'b0;
    compare_all();
  endtask

  initial begin
    // Reset state.
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 1, 0);
    check("rst_empty", bus.empty_o, 1);
    check("rst_level", bus.level_o, 0);

    // Three samples in, three out in order.
    cycle(1, 0, 0, 0, 100);
    cycle(1, 0, 0, 0, 200);
    cycle(1, 0, 0, 0, 300);
    check("t1_level", bus.level_o, 3);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, 0, 0);
      check("t1_valid", bus.rd_valid_o, 1);
      check("t1_x1", bus.x1_o, 64'(100 * (k + 1)));
      check("t1_seq", bus.seq_o, 64'(k));
    end
    cycle(0, 0, 0, 0, 0);
    check("t1_empty", bus.empty_o, 1);

    // Overfill by four, drain, next sample carries seq 20.
    cycle(0, 0, 0, 1, 0);
    for (int k = 0; k < 20; k++) cycle(1, 0, 0, 0, int'($urandom));
    check("t2_full", bus.full_o, 1);
    check("t2_level", bus.level_o, 16);
    check("t2_ovf", bus.ovf_o, 1);
`ifdef DEMOD_FIFO_DROP_COUNT_EN
    check("t2_drop", bus.drop_cnt_o, 4);
`endif
    for (int k = 0; k < 16; k++) begin
      cycle(0, 1, 0, 0, 0);
      check("t2_seq", bus.seq_o, 64'(k));
    end
    cycle(1, 0, 0, 0, 7);
    cycle(0, 1, 0, 0, 0);
    check("t2_seq20", bus.seq_o, 20);

    // Full FIFO with simultaneous tick and pop.
    cycle(0, 0, 1, 0, 0);
    for (int k = 0; k < 16; k++) cycle(1, 0, 0, 0, int'($urandom));
    cycle(1, 1, 0, 0, 55);
    check("t3_level", bus.level_o, 16);
    check("t3_ovf", bus.ovf_o, 0);
    check("t3_seq", bus.seq_o, 21);

    // Drain, then simultaneous tick and pop on an empty FIFO.
    for (int k = 0; k < 16; k++) cycle(0, 1, 0, 0, 0);
    check("t4_lastx1", bus.x1_o, 55);
    cycle(1, 1, 0, 0, 77);
    check("t4_novalid", bus.rd_valid_o, 0);
    check("t4_level", bus.level_o, 1);
    cycle(0, 1, 0, 0, 0);
    check("t4_x1", bus.x1_o, 77);

    // Pop while empty, then clear coinciding with a drop.
    cycle(0, 1, 0, 0, 0);
    check("t5_novalid", bus.rd_valid_o, 0);
    check("t5_hold", bus.x1_o, 77);
    cycle(0, 0, 1, 0, 0);
    for (int k = 0; k < 16; k++) cycle(1, 0, 0, 0, int'($urandom));
    cycle(1, 0, 1, 0, 0);
    check("t5_ovf", bus.ovf_o, 1);
`ifdef DEMOD_FIFO_DROP_COUNT_EN
    check("t5_drop", bus.drop_cnt_o, 1);
`endif

    // Reset with seven entries held.
    cycle(0, 0, 0, 1, 0);
    for (int k = 0; k < 7; k++) cycle(1, 0, 0, 0, int'($urandom));
    check("t6_level7", bus.level_o, 7);
    cycle(0, 0, 0, 1, 0);
    check("t6_level", bus.level_o, 0);
    check("t6_empty", bus.empty_o, 1);
    check("t6_ovf", bus.ovf_o, 0);
    cycle(1, 0, 0, 0, 9);
    cycle(0, 1, 0, 0, 0);
    check("t6_seq", bus.seq_o, 0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4,
            $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0, int'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demod_sample_fifo.md
# demod_sample_fifo

Buffers lock-in demodulator results for software readout so that every read returns a coherent sample set. Each accepted sample holds x1, i1, x2, i2 and a 32-bit sequence number. The block sits directly downstream of the QPD demodulator and is written on each demodulator done pulse. It replaces the free-running output-register snapshot with a FIFO that software drains through a pop-pulse handshake, with explicit drop accounting.

## Interface
Parameters:
- DEPTH, 16: number of sample entries; power of two, ≥ 4.
- DATA_W, 24: width of each demodulator channel.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- tick_i  in  1  single-cycle pulse; the x/i inputs are valid this cycle.
- x1_i, i1_i, x2_i, i2_i  in  DATA_W each, signed  demodulator outputs.
- rd_i  in  1  pop request, single-cycle pulse.
- clr_ovf_i  in  1  clears the overflow flag (and the drop counter, if compiled in).
- x1_o, i1_o, x2_o, i2_o  out  DATA_W each, signed  popped sample.
- seq_o  out  32  sequence number of the popped sample.
- rd_valid_o  out  1  one-cycle pulse; popped outputs have been updated.
- level_o  out  $clog2(DEPTH)+1  number of occupied entries.
- empty_o, full_o  out  1  FIFO status.
- ovf_o  out  1  sticky flag; at least one sample has been dropped.
- drop_cnt_o  out  32  dropped-sample count; present only with the macro.

## Operation
- seq counter increments on every tick_i, whether the sample is accepted or dropped. The stored value is the count before the increment, so the first sample after reset has seq 0. Gaps in seq_o therefore expose drops.
- Write: tick_i with the FIFO not full stores {seq, x1, i1, x2, i2} at wr_ptr, then wr_ptr increments.
- Drop: tick_i with the FIFO full discards the sample and sets ovf_o. The stored data is unchanged.
- Pop: rd_i with the FIFO not empty reads the entry at rd_ptr into the output registers, then rd_ptr increments.
- rd_i with the FIFO empty is ignored: no rd_valid_o, outputs hold.
- Simultaneous tick_i and rd_i:
  - When full, both the pop and the write succeed and level is unchanged. No drop occurs.
  - When empty, the write succeeds and the pop is ignored. There is no fall-through.
  - Otherwise both succeed and level is unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally. level is tracked as a separate counter.
- Simultaneous clr_ovf_i and a drop: the drop wins and ovf_o stays 1.
- Reset mid-operation discards all entries; RAM contents are left undefined.
- Reset values: all outputs 0, empty_o 1, full_o 0, level_o 0, seq counter 0.

## Timing
- Pop latency: rd_i in cycle N gives data_o and rd_valid_o in cycle N+1. The output registers hold until the next valid pop.
- Write-to-visibility: tick_i in cycle N updates level_o, empty_o and full_o in cycle N+1. A pop issued in cycle N+1 may read that entry.
- The status outputs are registered; none are combinational from the inputs.
- There is no required minimum spacing between tick_i pulses or between rd_i pulses. Back-to-back pops each take one cycle.

## Configuration
- DEMOD_FIFO_DROP_COUNT_EN defined:
  - drop_cnt_o exists.
  - It increments on each dropped sample and saturates at 0xFFFFFFFF.
  - clr_ovf_i clears it. A drop in the same cycle as clr_ovf_i loads 1.
- Not defined: the port and the counter are absent; ovf_o alone reports drops.

## Structure
- Package demod_pkg:
  - DATA_W default constant.
  - typedef demod_sample_t, struct packed {seq[31:0], x1, i1, x2, i2}.
  - SEQ_W = 32.
- Sub-module demod_sample_ram: simple dual-port RAM of demod_sample_t. It has a synchronous write and a registered synchronous read, and infers block or distributed RAM.
- FIFO control (pointers, level, flags, seq counter) lives in the top module.

## Test plan
- After reset, 3 ticks with x1 = 100, 200, 300 → level_o = 3. Three pops return x1 100/200/300 with seq 0/1/2, each rd_valid_o one cycle after rd_i. empty_o = 1 at the end.
- DEPTH = 16; 20 ticks with no reads → full_o = 1, level_o = 16, ovf_o = 1, drop_cnt_o = 4. Draining returns seq 0..15. The next tick stores seq 20.
- When full, tick_i and rd_i in the same cycle → the pop returns the oldest entry, level stays 16, ovf_o does not change, and the new sample is stored.
- When empty, tick_i and rd_i in the same cycle → no rd_valid_o and level_o = 1. A later pop returns that sample.
- rd_i while empty → no rd_valid_o and outputs unchanged. clr_ovf_i in the same cycle as a drop → ovf_o = 1 and drop_cnt_o = 1.
- Reset asserted with level 7 → the next cycle shows level 0, empty 1, ovf 0 and outputs 0. The first subsequent sample has seq 0.
